// File: rtl/add64_seq_pkg.sv
// Shared widths and state encoding for the two-pass 64-bit add/subtract sequencer.
package add64_seq_pkg;

  localparam int XLEN = 64;
  localparam int HALF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/add64_seq_if.sv
// Bus between the execute stage, the add64_seq sequencer and the external 32-bit adder core.
interface add64_seq_if;
  import add64_seq_pkg::*;

  // Handshake: start is a request taken only in a cycle where busy=0. Once taken,
  // busy stays high until done. done is a one-cycle pulse in which result and
  // flags become valid; they then hold until the next done or reset.
  logic            start;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            sub;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            carry;
  logic            overflow;
  logic            zero;
  logic [HALF-1:0] add_a;
  logic [HALF-1:0] add_b;
  logic            add_cin;
  logic [HALF-1:0] add_sum;
  logic            add_cout;

  modport slave (
    input  start, op_a, op_b, sub, add_sum, add_cout,
    output busy, done, result, carry, overflow, zero, add_a, add_b, add_cin
  );

  modport master (
    output start, op_a, op_b, sub, add_sum, add_cout,
    input  busy, done, result, carry, overflow, zero, add_a, add_b, add_cin
  );

endinterface

// File: rtl/add64_seq.sv
// 64-bit add/subtract built from two passes through an external 32-bit adder core,
// low half first, with the carry chained into the high half.
module add64_seq
  import add64_seq_pkg::*;
#(
    parameter int ADD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    add64_seq_if.slave  bus,
    output state_e      dbg_state_o
);

    // Index of the final cycle in each half-pass; the 1-bit wait counter counts up to it.
    localparam logic LAT_LAST = (ADD_LAT != 0);

    state_e          state_q, state_d;
    logic            cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, bop_q;
    logic            sub_q;
    logic [HALF-1:0] res_lo_q;
    logic            c_mid_q;
    logic [XLEN-1:0] result_q;
    logic            carry_q, overflow_q, zero_q;

    logic            last_cyc;
    logic            accept, cap_lo, cap_hi;
    logic [HALF-1:0] add_a_d, add_b_d;
    logic            add_cin_d;
    logic [XLEN-1:0] sum_full;

    assign last_cyc = (cnt_q == LAT_LAST);
    assign sum_full = {bus.add_sum, res_lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        add_a_d   = '0;
        add_b_d   = '0;
        add_cin_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = LO;
                    cnt_d   = 1'b0;
                end
            end
            LO: begin
                add_a_d   = a_q[HALF-1:0];
                add_b_d   = bop_q[HALF-1:0];
                add_cin_d = sub_q;
                if (last_cyc) begin
                    cap_lo  = 1'b1;
                    state_d = HI;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                add_a_d   = a_q[XLEN-1:HALF];
                add_b_d   = bop_q[XLEN-1:HALF];
                add_cin_d = c_mid_q;
                if (last_cyc) begin
                    cap_hi  = 1'b1;
                    state_d = FIN;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 1'b0;
            a_q        <= '0;
            bop_q      <= '0;
            sub_q      <= 1'b0;
            res_lo_q   <= '0;
            c_mid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Subtract is A + ~B + 1: invert B once here, the +1 enters as the low-half carry-in.
            if (accept) begin
                a_q   <= bus.op_a;
                bop_q <= bus.sub ? ~bus.op_b : bus.op_b;
                sub_q <= bus.sub;
            end
            if (cap_lo) begin
                res_lo_q <= bus.add_sum;
                c_mid_q  <= bus.add_cout;
            end
            // The high half lands straight in the result so it is valid in the FIN cycle.
            if (cap_hi) begin
                result_q   <= sum_full;
                carry_q    <= bus.add_cout;
                overflow_q <= (a_q[XLEN-1] == bop_q[XLEN-1]) && (bus.add_sum[HALF-1] != a_q[XLEN-1]);
                zero_q     <= (sum_full == '0);
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.add_a    = add_a_d;
    assign bus.add_b    = add_b_d;
    assign bus.add_cin  = add_cin_d;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_add64_seq.sv
// Bench for add64_seq: one instance with a 1-cycle adder core, one with a combinational core.
module tb_add64_seq;
  import add64_seq_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  add64_seq_if if1 ();
  add64_seq_if if0 ();
  state_e st1, st0;

  logic        start, use0, sub;
  logic [63:0] op_a, op_b;

  assign if1.start = start & ~use0;
  assign if0.start = start & use0;
  assign if1.op_a = op_a;
  assign if0.op_a = op_a;
  assign if1.op_b = op_b;
  assign if0.op_b = op_b;
  assign if1.sub = sub;
  assign if0.sub = sub;

  // Adder cores: registered (latency 1) and combinational (latency 0)
  always @(posedge clock)
    {if1.add_cout, if1.add_sum} <= {1'b0, if1.add_a} + {1'b0, if1.add_b} + {32'd0, if1.add_cin};
  assign {if0.add_cout, if0.add_sum} = {1'b0, if0.add_a} + {1'b0, if0.add_b} + {32'd0, if0.add_cin};

  add64_seq #(.ADD_LAT(1)) u1 (.clock(clock), .reset(reset), .bus(if1), .dbg_state_o(st1));
  add64_seq #(.ADD_LAT(0)) u0 (.clock(clock), .reset(reset), .bus(if0), .dbg_state_o(st0));

  logic        m_done, m_busy, m_cin;
  logic [63:0] m_result;
  logic [31:0] m_add_a, m_add_b;
  logic [66:0] m_flags;
  assign m_done   = use0 ? if0.done : if1.done;
  assign m_busy   = use0 ? if0.busy : if1.busy;
  assign m_cin    = use0 ? if0.add_cin : if1.add_cin;
  assign m_result = use0 ? if0.result : if1.result;
  assign m_add_a  = use0 ? if0.add_a : if1.add_a;
  assign m_add_b  = use0 ? if0.add_b : if1.add_b;
  assign m_flags  = use0 ? {if0.zero, if0.overflow, if0.carry, if0.result}
                         : {if1.zero, if1.overflow, if1.carry, if1.result};

  int total = 0;
  int bad   = 0;
  logic [66:0] exp_q[$];

  // Reference: {zero, overflow, carry, result} from a plain 65-bit sum
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] bop;
    logic [64:0] sm;
    logic        ovf;
    bop = s ? ~b : b;
    sm  = {1'b0, a} + {1'b0, bop} + {64'd0, s};
    ovf = (a[63] == bop[63]) && (sm[63] != a[63]);
    return {(sm[63:0] == 64'd0), ovf, sm[64], sm[63:0]};
  endfunction

  // Presents one request for a cycle; returns in the cycle after acceptance (T+1)
  task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    @(negedge clock);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(negedge clock);
    start = 1'b0;
    op_a  = {$urandom(), $urandom()};
    op_b  = {$urandom(), $urandom()};
    sub   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(inout int cyc);
    while (m_done !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    use0 = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    op_a = 64'd1;
    op_b = 64'd2;
    sub = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({if1.busy, if1.done, if1.result, if1.carry, if1.overflow, if1.zero,
         if1.add_a, if1.add_b, if1.add_cin, st1} !== '0)
      begin bad++; $display("FAIL reset_l1 busy=%b done=%b result=%h add_a=%h state=%0d required all 0",
                            if1.busy, if1.done, if1.result, if1.add_a, st1); end
    total++;
    if ({if0.busy, if0.done, if0.result, if0.carry, if0.overflow, if0.zero,
         if0.add_a, if0.add_b, if0.add_cin, st0} !== '0)
      begin bad++; $display("FAIL reset_l0 busy=%b done=%b result=%h state=%0d required all 0",
                            if0.busy, if0.done, if0.result, st0); end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic_add;
    int cyc;
    logic [66:0] e;
    use0 = 1'b0;
    drive_op(64'd111, 64'd222, 1'b0);
    cyc = 1;
    while (m_done !== 1'b1 && cyc < 20) begin
      total++;
      if (m_busy !== 1'b1) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b required=1", cyc, m_busy); end
      @(negedge clock);
      cyc++;
    end
    total++;
    if (cyc != 5) begin bad++; $display("FAIL basic_latency got=%0d required=5", cyc); end
    total++;
    if (m_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done got=%b required=1", m_busy); end
    e = exp_q.pop_front();
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL basic_result got=%h required=%h", m_flags, e); end
    @(negedge clock);
    total++;
    if ({m_done, m_busy} !== 2'b00) begin bad++; $display("FAIL basic_after_done done/busy got=%b required=00", {m_done, m_busy}); end
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL basic_hold got=%h required=%h", m_flags, e); end
  endtask

  task automatic test_carry_cross;
    int cyc;
    logic [66:0] e;
    use0 = 1'b0;
    drive_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    total++;
    if ({m_add_a, m_add_b, m_cin} !== {32'hFFFF_FFFF, 32'd1, 1'b0})
      begin bad++; $display("FAIL carry_lo_inputs got=%h/%h/%b required=ffffffff/00000001/0", m_add_a, m_add_b, m_cin); end
    repeat (2) @(negedge clock);
    total++;
    if ({m_add_a, m_cin} !== {32'd0, 1'b1})
      begin bad++; $display("FAIL carry_hi_cin got add_a=%h cin=%b required 00000000/1", m_add_a, m_cin); end
    cyc = 3;
    wait_done(cyc);
    total++;
    if (cyc != 5) begin bad++; $display("FAIL carry_latency got=%0d required=5", cyc); end
    e = exp_q.pop_front();
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL carry_result got=%h required=%h", m_flags, e); end
  endtask

  task automatic test_flags;
    logic [63:0] ta [4] = '{64'd5, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] tb [4] = '{64'd7, 64'd5, 64'd1, 64'd1};
    logic        ts [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [66:0] fixed [4] = '{{1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE},
                               {1'b0, 1'b0, 1'b1, 64'd2},
                               {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000},
                               {1'b1, 1'b0, 1'b1, 64'd0}};
    int cyc;
    logic [66:0] e;
    use0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_op(ta[i], tb[i], ts[i]);
      cyc = 1;
      wait_done(cyc);
      e = exp_q.pop_front();
      total++;
      if (m_flags !== e) begin bad++; $display("FAIL flags_%0d got=%h required=%h", i, m_flags, e); end
      total++;
      if (m_flags !== fixed[i]) begin bad++; $display("FAIL flags_const_%0d got=%h required=%h", i, m_flags, fixed[i]); end
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    int extra;
    logic [66:0] e;
    use0 = 1'b0;
    drive_op(64'd111, 64'd222, 1'b0);
    @(negedge clock);
    op_a = 64'd444;
    op_b = 64'd555;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 3;
    wait_done(cyc);
    total++;
    if (cyc != 5) begin bad++; $display("FAIL busy_latency got=%0d required=5", cyc); end
    e = exp_q.pop_front();
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL busy_result got=%h required=%h", m_flags, e); end
    // A request in the FIN cycle must also be dropped
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++;
    if (m_busy !== 1'b0) begin bad++; $display("FAIL busy_fin_start got busy=%b required=0", m_busy); end
    extra = 0;
    repeat (10) begin
      if (m_done === 1'b1) extra++;
      @(negedge clock);
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL busy_extra_done got=%0d required=0", extra); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    logic [66:0] e;
    use0 = 1'b0;
    drive_op(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0002, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    void'(exp_q.pop_front());
    total++;
    if ({m_busy, m_done, m_result, m_add_a} !== '0)
      begin bad++; $display("FAIL reset_mid got busy=%b done=%b result=%h add_a=%h required all 0",
                            m_busy, m_done, m_result, m_add_a); end
    seen = 0;
    repeat (6) begin
      if (m_done === 1'b1) seen++;
      @(negedge clock);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid_done got=%0d required=0", seen); end
    drive_op(64'd222, 64'd333, 1'b0);
    cyc = 1;
    wait_done(cyc);
    total++;
    if (cyc != 5) begin bad++; $display("FAIL reset_fresh_latency got=%0d required=5", cyc); end
    e = exp_q.pop_front();
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL reset_fresh_result got=%h required=%h", m_flags, e); end
  endtask

  task automatic test_lat0;
    int cyc;
    logic [66:0] e;
    use0 = 1'b1;
    drive_op(64'd111, 64'd222, 1'b0);
    cyc = 1;
    wait_done(cyc);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL lat0_latency got=%0d required=3", cyc); end
    e = exp_q.pop_front();
    total++;
    if (m_flags !== e) begin bad++; $display("FAIL lat0_result got=%h required=%h", m_flags, e); end
    @(negedge clock);
    total++;
    if (m_done !== 1'b0) begin bad++; $display("FAIL lat0_pulse got=%b required=0", m_done); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [66:0] e;
    for (int i = 0; i < 16; i++) begin
      use0 = 1'(i % 2);
      drive_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      cyc = 1;
      wait_done(cyc);
      e = exp_q.pop_front();
      total++;
      if (m_flags !== e) begin bad++; $display("FAIL b2b_%0d got=%h required=%h", i, m_flags, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    use0 = 1'b0;
    sub = 1'b0;
    op_a = '0;
    op_b = '0;
    reset = 1'b1;
    test_reset;
    test_basic_add;
    test_carry_cross;
    test_flags;
    test_start_while_busy;
    test_reset_mid;
    test_lat0;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add64_seq.md
Name: add64_seq

Overview:
- Sequencer that performs 64-bit add/subtract on the processor datapath using one external 32-bit prefix-adder core over two passes.
- Sits directly upstream of the adder core. It splits the operands, drives the core's a/b/carry-in inputs, consumes its sum/carry-out, chains the carry between halves, and assembles the 64-bit result and flags for the execute stage.

Parameters:
- ADD_LAT, 1, adder core latency in cycles: inputs presented in cycle t give a valid sum/cout in cycle t+ADD_LAT. Legal values are 0 and 1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op_a  in  64  operand A, sampled on accept
- op_b  in  64  operand B, sampled on accept
- sub  in  1  1 = A-B, 0 = A+B; sampled on accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result and flags valid
- result  out  64  registered sum/difference
- carry  out  1  64-bit carry-out; for subtract, 1 = no borrow
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- add_a  out  32  to adder core, operand a
- add_b  out  32  to adder core, operand b
- add_cin  out  1  to adder core, carry-in
- add_sum  in  32  from adder core, sum
- add_cout  in  1  from adder core, carry-out

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, result, carry, overflow and zero are all 0.
  - add_a, add_b and add_cin are 0.
  - Reset wins over every other input in the same cycle.
- States:
  - IDLE → LO on start.
  - LO is held ADD_LAT+1 cycles, then → HI.
  - HI is held ADD_LAT+1 cycles, then → FIN.
  - FIN → IDLE.
  - A wait counter (width 1) tracks the ADD_LAT hold.
- Accept (cycle T, IDLE with start=1):
  - Latch op_a, bop = sub ? ~op_b : op_b, and sub.
  - busy rises in T+1 and stays high through the done cycle.
- LO (from T+1):
  - add_a = a[31:0], add_b = bop[31:0], add_cin = sub.
  - Inputs are held stable for the whole stay.
  - On the last LO cycle (T+1+ADD_LAT), capture add_sum into res_lo and add_cout into c_mid.
- HI:
  - add_a = a[63:32], add_b = bop[63:32], add_cin = c_mid.
  - On the last HI cycle (T+2+2·ADD_LAT), capture add_sum into res_hi and add_cout into carry.
- FIN (cycle T+3+2·ADD_LAT):
  - done=1 for exactly one cycle.
  - result = {res_hi, res_lo}.
  - overflow = (a[63] == bop[63]) && (result[63] != a[63]).
  - zero = (result == 0).
  - Result and flags are registered and valid in this same cycle.
- Latency:
  - start to done is 5 cycles for ADD_LAT=1 and 3 cycles for ADD_LAT=0.
  - Throughput is one operation per latency+1 cycles.
- Hold:
  - result and flags hold their values until the next done or reset.
  - done is 0 at all other times.
- Adder ports when not in LO/HI: add_a, add_b and add_cin are driven to 0.
- start while busy=1 (including the FIN cycle): ignored, with no effect on the operation in flight.
- Operand wrap: arithmetic is modulo 2^64; carry reports the bit-64 carry.
- Reset mid-operation: abort immediately with no done pulse; outputs take their reset values.
- Operands and sub changing after accept: no effect on the operation in flight.

Decomposition:
- Shared package holds:
  - Datapath widths: XLEN=64, HALF=32.
  - State encoding: IDLE, LO, HI, FIN (2-bit).
- No sub-module. The 32-bit adder core is instantiated by the parent and wired to the add_* ports; the bench instantiates the core alongside this block.

Test Plan:
- Basic add, ADD_LAT=1: op_a=111, op_b=222, sub=0, start in cycle T → done in T+5, result=333, carry=0, overflow=0, zero=0; busy high T+1..T+5.
- Carry crossing halves: op_a=0x0000_0000_FFFF_FFFF, op_b=1, add → result=0x0000_0001_0000_0000, carry=0; in the HI phase, add_cin=1 is observed.
- Subtract: op_a=5, op_b=7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0. Then op_a=7, op_b=5, sub=1 → result=2, carry=1.
- Overflow and zero:
  - 0x7FFF_FFFF_FFFF_FFFF + 1 → result=0x8000_0000_0000_0000, overflow=1.
  - 0xFFFF_FFFF_FFFF_FFFF + 1 → result=0, carry=1, zero=1, overflow=0.
- Start while busy: a second start with 444+555 in T+2 → only one done, result=333; the second request is dropped.
- Reset mid-operation: assert reset in T+3 → no done; the next cycle shows busy=0, result=0, add_a=0. A fresh 222+333 then completes with result=555. Repeat the basic add with ADD_LAT=0 → done in T+3.
